// File: rtl/ecu_gpio_pkg.sv
// Shared register map and EDGE_SEL bit positions for the ecu_gpio controller.
package ecu_gpio_pkg;

    localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd2;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd3;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd4;
    localparam logic [2:0] ADDR_DB_LIMIT = 3'd5;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd6;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd7;

    localparam int EDGE_RISE_BIT = 0;
    localparam int EDGE_FALL_BIT = 1;

endpackage

// File: rtl/ecu_gpio_debounce.sv
// One input channel: 2-flop synchroniser, debounce counter and stable state,
// with single-cycle pulses on the cycle the stable value commits.
module ecu_gpio_debounce #(
    parameter int   CNT_W    = 20,
    parameter logic IN_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             raw,
    input  logic [CNT_W-1:0] limit,
    output logic             stable,
    output logic             rise_pulse,
    output logic             fall_pulse
);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             commit;

    // The >= compare keeps a counter above a freshly lowered limit from wrapping.
    assign commit = (sync2_reg != stable_reg) && (cnt_reg >= limit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg  <= IN_RESET;
            sync2_reg  <= IN_RESET;
            stable_reg <= IN_RESET;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (commit) begin
                stable_reg <= sync2_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign stable     = stable_reg;
    assign rise_pulse = commit &  sync2_reg;
    assign fall_pulse = commit & ~sync2_reg;

endmodule

// File: rtl/ecu_gpio_ctrl.sv
// Avalon-MM GPIO controller: debounced inputs with edge capture and maskable
// irq, plus outputs with direct, set and clear write ports.
module ecu_gpio_ctrl
    import ecu_gpio_pkg::*;
#(
    parameter int              N_IN      = 14,
    parameter int              N_OUT     = 10,
    parameter int              CNT_W     = 20,
    parameter int              DB_RESET  = 250000,
    parameter logic [N_IN-1:0] IN_RESET  = '1,
    parameter logic [N_OUT-1:0] OUT_RESET = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    output logic [31:0]      avs_readdata,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    input  logic [N_IN-1:0]  gpio_in,
    output logic [N_OUT-1:0] gpio_out,
    output logic             irq
);

    logic [N_IN-1:0]  stable;
    logic [N_IN-1:0]  rise;
    logic [N_IN-1:0]  fall;

    logic [N_OUT-1:0] data_out_reg;
    logic [N_OUT-1:0] data_out_next;
    logic [N_IN-1:0]  edge_cap_reg;
    logic [N_IN-1:0]  edge_cap_next;
    logic [N_IN-1:0]  irq_mask_reg;
    logic [1:0]       edge_sel_reg;
    logic [CNT_W-1:0] db_limit_reg;
    logic [31:0]      readdata_reg;
    logic [31:0]      readdata_next;
    logic             irq_reg;

    logic [N_IN-1:0]  w1c;
    logic [N_IN-1:0]  new_edge;
    logic             unused_wdata;

    assign unused_wdata = ^avs_writedata;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_ch
            ecu_gpio_debounce #(
                .CNT_W    (CNT_W),
                .IN_RESET (IN_RESET[gi])
            ) u_db (
                .clk        (clk),
                .reset_n    (reset_n),
                .raw        (gpio_in[gi]),
                .limit      (db_limit_reg),
                .stable     (stable[gi]),
                .rise_pulse (rise[gi]),
                .fall_pulse (fall[gi])
            );
        end
    endgenerate

    // A new edge overrides a simultaneous W1C on the same bit.
    always_comb begin
        w1c = '0;
        if (avs_write && avs_address == ADDR_EDGE_CAP) begin
            w1c = avs_writedata[N_IN-1:0];
        end
        new_edge      = (rise & {N_IN{edge_sel_reg[EDGE_RISE_BIT]}})
                      | (fall & {N_IN{edge_sel_reg[EDGE_FALL_BIT]}});
        edge_cap_next = (edge_cap_reg & ~w1c) | new_edge;
    end

    always_comb begin
        data_out_next = data_out_reg;
        if (avs_write) begin
            case (avs_address)
                ADDR_DATA_OUT: data_out_next = avs_writedata[N_OUT-1:0];
                ADDR_OUT_SET:  data_out_next = data_out_reg | avs_writedata[N_OUT-1:0];
                ADDR_OUT_CLR:  data_out_next = data_out_reg & ~avs_writedata[N_OUT-1:0];
                default:       data_out_next = data_out_reg;
            endcase
        end
    end

    always_comb begin
        readdata_next = '0;
        if (avs_read) begin
            case (avs_address)
                ADDR_DATA_IN:  readdata_next[N_IN-1:0]  = stable;
                ADDR_DATA_OUT: readdata_next[N_OUT-1:0] = data_out_reg;
                ADDR_EDGE_CAP: readdata_next[N_IN-1:0]  = edge_cap_reg;
                ADDR_IRQ_MASK: readdata_next[N_IN-1:0]  = irq_mask_reg;
                ADDR_EDGE_SEL: readdata_next[1:0]       = edge_sel_reg;
                ADDR_DB_LIMIT: readdata_next[CNT_W-1:0] = db_limit_reg;
                default:       readdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_reg <= OUT_RESET;
            edge_cap_reg <= '0;
            irq_mask_reg <= '0;
            edge_sel_reg <= 2'b11;
            db_limit_reg <= CNT_W'(DB_RESET);
            readdata_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            data_out_reg <= data_out_next;
            edge_cap_reg <= edge_cap_next;
            readdata_reg <= readdata_next;
            irq_reg      <= |(edge_cap_reg & irq_mask_reg);
            if (avs_write) begin
                case (avs_address)
                    ADDR_IRQ_MASK: irq_mask_reg <= avs_writedata[N_IN-1:0];
                    ADDR_EDGE_SEL: edge_sel_reg <= avs_writedata[1:0];
                    ADDR_DB_LIMIT: db_limit_reg <= avs_writedata[CNT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign gpio_out     = data_out_reg;
    assign avs_readdata = readdata_reg;
    assign irq          = irq_reg;

endmodule
